spart_bus_arb: RTL and testbench
================================

# spart_bus_arb

Sequencer and arbiter for the SPART processor-side register bus. It programs the baud-rate divisor after reset and on request. It then shares the single transmit buffer between `NREQ` byte-producing clients using round-robin arbitration, and drains the receive buffer to a broadcast output. It sits between the clients and the SPART and is the only block that drives `iocs`, `iorw`, `ioaddr` or `databus`.

## Interface
- `NREQ`, default 2: number of transmit requesters (2..8).
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `br_cfg`  in  2: baud select, sampled only in CFG_LO.
- `cfg_req`  in  1: single-cycle pulse requesting divisor reprogramming.
- `tx_req`  in  NREQ: per-client transmit request; held until acked.
- `tx_data`  in  8*NREQ: client i byte at [8i+7:8i]; stable while tx_req[i]=1.
- `tx_ack`  out  NREQ: one-cycle pulse, byte of that client written.
- `rx_valid`  out  1: one-cycle pulse, rx_data holds a new byte.
- `rx_data`  out  8: last received byte; holds value until the next read.
- `busy`  out  1: high whenever state is not READY.
- `iocs`, `iorw`  out  1 each: SPART chip select; iorw 1 = read, 0 = write.
- `ioaddr`  out  2: 00 TX/RX buffer, 01 status (never accessed), 10 divisor low, 11 divisor high.
- `rda`, `tbr`  in  1 each: SPART receive-data-available and transmit-buffer-ready.
- `databus`  inout  8: driven only during write cycles, otherwise high-Z.

## Operation
- States: IDLE, CFG_LO, CFG_HI, READY, RX_RD, RX_HOLD, TX_WR, TX_HOLD.
- Divisor table (latched into `div_q[15:0]` in CFG_LO):
  - 00 → 1301 (0x0515)
  - 01 → 650 (0x028A)
  - 10 → 325 (0x0145)
  - 11 → 162 (0x00A2)
- IDLE → CFG_LO unconditionally.
- CFG_LO: write div_q[7:0] to addr 10, go to CFG_HI. Drive the byte combinationally from br_cfg this cycle and latch simultaneously.
- CFG_HI: write div_q[15:8] to addr 11, go to READY, clear cfg_pend.
- cfg_req sets sticky flag cfg_pend in any state.
- READY priority, highest first:
  - cfg_pend → CFG_LO.
  - rda → RX_RD.
  - tbr and |tx_req → TX_WR.
  - Otherwise stay in READY.
- RX_RD: iocs=1, iorw=1, ioaddr=00. The databus value is captured into rx_data at the edge leaving RX_RD. Then go to RX_HOLD.
- RX_HOLD: rx_valid=1 this cycle; bus inactive; go to READY. This gives rda one cycle to fall.
- Grant selection on READY→TX_WR: the winner is the first asserted tx_req strictly after rr_ptr, searching upward with wrap, and is registered as gnt.
- TX_WR: iocs=1, iorw=0, ioaddr=00, databus = tx_data[gnt]. tx_ack[gnt]=1 this cycle. rr_ptr ← gnt. Go to TX_HOLD.
- TX_HOLD: bus inactive; go to READY. This gives tbr one cycle to fall.
- A client dropping tx_req before ack simply withdraws; it is never acked late.
- The arbiter never issues a TX write while tbr=0.

## Timing
- Reset values of outputs:
  - iocs=0, iorw=1, ioaddr=00, databus=Z.
  - tx_ack=0, rx_valid=0, rx_data=00, busy=1.
- Reset values of internal state: rr_ptr=NREQ-1, so client 0 wins first; cfg_pend=0.
- Bus-inactive cycles: iocs=0, iorw=1, ioaddr=00, databus=Z.
- Every access asserts iocs for exactly one cycle. All bus outputs are decoded from the registered state.
- After rst_n rises:
  - Edge 1 → CFG_LO.
  - Edge 2 → CFG_HI.
  - Edge 3 → READY.
  - The first client access starts no earlier than edge 4.
- Latency from READY to:
  - RX: rda seen to rx_valid is 2 cycles.
  - TX: tx_req seen to tx_ack is 1 cycle.
- Minimum spacing between accesses: 3 cycles per RX or TX transaction.
- cfg_req arriving mid-transaction is serviced at the next READY, ahead of pending rda and tx_req.
- rst_n low mid-transaction forces reset values immediately, with no clock edge needed. A pending ack or rx_valid is lost.

## Test plan
- Reset with br_cfg=01: expect writes 0x8A@10 then 0x02@11 on consecutive cycles, then busy=0. No access before that.
- tx_req=2'b11, tbr=1 held, tx_data={8'hB2,8'hA1}: acks alternate client 0,1,0,1. Bus writes are A1,B2,A1,B2 at addr 00, each 3 cycles apart.
- rda and tx_req[1] rise in the same READY cycle: RX_RD occurs first. rx_valid pulses with the databus byte 0x5C two cycles later. The TX write follows from the next READY.
- tx_req[0]=1 with tbr=0 for 10 cycles: no iocs and no tx_ack. tbr rising gives tx_ack[0] on the next cycle.
- cfg_req pulsed during TX_WR with br_cfg=11: TX completes, then writes 0xA2@10, 0x00@11, then READY.
- rst_n pulled low during TX_WR: iocs=0 and databus=Z asynchronously. After release, the full configuration sequence reruns and client 0 has priority.

Source files
------------

// File: rtl/spart_bus_arb_if.sv
// rtl/spart_bus_arb_if.sv - client handshake and SPART control signals for spart_bus_arb
interface spart_bus_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   tx_req;
    logic [8*NREQ-1:0] tx_data;
    logic [NREQ-1:0]   tx_ack;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              iocs;
    logic              iorw;
    logic [1:0]        ioaddr;
    logic              rda;
    logic              tbr;

    // The arbiter side: owns chip select, address and the client acknowledges.
    modport master (
        input  tx_req, tx_data, rda, tbr,
        output tx_ack, rx_valid, rx_data, iocs, iorw, ioaddr
    );

    // The environment side: clients and the SPART itself.
    modport slave (
        output tx_req, tx_data, rda, tbr,
        input  tx_ack, rx_valid, rx_data, iocs, iorw, ioaddr
    );
endinterface

// File: rtl/spart_bus_arb.sv
// rtl/spart_bus_arb.sv - SPART register-bus sequencer with round-robin transmit arbitration
module spart_bus_arb #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      br_cfg,
    input  logic            cfg_req,
    output logic            busy,
    inout  wire  [7:0]      databus,
    spart_bus_arb_if.master bus
);
    localparam int GW = $clog2(NREQ);
    localparam logic [GW:0] NREQ_W = (GW+1)'(NREQ);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CFG_LO  = 3'd1;
    localparam logic [2:0] S_CFG_HI  = 3'd2;
    localparam logic [2:0] S_READY   = 3'd3;
    localparam logic [2:0] S_RX_RD   = 3'd4;
    localparam logic [2:0] S_RX_HOLD = 3'd5;
    localparam logic [2:0] S_TX_WR   = 3'd6;
    localparam logic [2:0] S_TX_HOLD = 3'd7;

    logic [2:0]    state_q, state_d;
    // The low divisor byte leaves on the bus in the same cycle it is selected,
    // so only the high byte has to be held for the following write.
    logic [7:0]    div_hi_q, div_hi_d;
    logic          cfg_pend_q, cfg_pend_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [7:0]    rx_data_q, rx_data_d;

    logic [15:0]   div_sel;
    logic [GW-1:0] win;
    logic          win_found;
    logic [GW:0]   cand;
    logic          drv_en;
    logic [7:0]    drv_byte;

    // Baud select to divisor lookup.
    always_comb begin
        div_sel = 16'h0515;
        case (br_cfg)
            2'b00:   div_sel = 16'h0515;
            2'b01:   div_sel = 16'h028A;
            2'b10:   div_sel = 16'h0145;
            default: div_sel = 16'h00A2;
        endcase
    end

    // Round-robin winner: first requester strictly after the last served client, with wrap.
    always_comb begin
        win       = rr_ptr_q;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!win_found && bus.tx_req[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win       = cand[GW-1:0];
            end
        end
    end

    // Sequencer next state: configuration first, then READY dispatch cfg > rx > tx.
    always_comb begin
        state_d    = state_q;
        div_hi_d   = div_hi_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        rx_data_d  = rx_data_q;
        cfg_pend_d = cfg_pend_q | cfg_req;
        case (state_q)
            S_IDLE: begin
                state_d = S_CFG_LO;
            end
            S_CFG_LO: begin
                div_hi_d = div_sel[15:8];
                state_d  = S_CFG_HI;
            end
            S_CFG_HI: begin
                // A request landing on this very edge must survive the clear.
                cfg_pend_d = cfg_req;
                state_d    = S_READY;
            end
            S_READY: begin
                if (cfg_pend_q) begin
                    state_d = S_CFG_LO;
                end else if (bus.rda) begin
                    state_d = S_RX_RD;
                end else if (bus.tbr && win_found) begin
                    gnt_d   = win;
                    state_d = S_TX_WR;
                end
            end
            S_RX_RD: begin
                rx_data_d = databus;
                state_d   = S_RX_HOLD;
            end
            S_RX_HOLD: begin
                state_d = S_READY;
            end
            S_TX_WR: begin
                rr_ptr_d = gnt_q;
                state_d  = S_TX_HOLD;
            end
            S_TX_HOLD: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset parks the bus and points rr_ptr so client 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_hi_q   <= 8'h00;
            cfg_pend_q <= 1'b0;
            rr_ptr_q   <= GW'(NREQ - 1);
            gnt_q      <= '0;
            rx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            div_hi_q   <= div_hi_d;
            cfg_pend_q <= cfg_pend_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Bus decode from the registered state; every access lasts exactly one state.
    always_comb begin
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b1;
        bus.ioaddr = 2'b00;
        bus.tx_ack = '0;
        drv_en     = 1'b0;
        drv_byte   = 8'h00;
        case (state_q)
            S_CFG_LO: begin
                bus.iocs   = 1'b1;
                bus.iorw   = 1'b0;
                bus.ioaddr = 2'b10;
                drv_en     = 1'b1;
                drv_byte   = div_sel[7:0];
            end
            S_CFG_HI: begin
                bus.iocs   = 1'b1;
                bus.iorw   = 1'b0;
                bus.ioaddr = 2'b11;
                drv_en     = 1'b1;
                drv_byte   = div_hi_q;
            end
            S_RX_RD: begin
                bus.iocs = 1'b1;
            end
            S_TX_WR: begin
                bus.iocs          = 1'b1;
                bus.iorw          = 1'b0;
                drv_en            = 1'b1;
                drv_byte          = bus.tx_data[{gnt_q, 3'b000} +: 8];
                bus.tx_ack[gnt_q] = 1'b1;
            end
            default: begin
                drv_en = 1'b0;
            end
        endcase
    end

    assign databus      = drv_en ? drv_byte : 8'hzz;
    assign bus.rx_valid = (state_q == S_RX_HOLD);
    assign bus.rx_data  = rx_data_q;
    assign busy         = (state_q != S_READY);
endmodule

// File: tb/tb_spart_bus_arb.sv
// tb/tb_spart_bus_arb.sv - self-checking bench for spart_bus_arb
module tb_spart_bus_arb;
    localparam int NREQ = 2;
    localparam int K_IDLE = 0, K_READY = 1, K_CLO = 2, K_CHI = 3;
    localparam int K_RD = 4, K_RXH = 5, K_WR = 6, K_TXH = 7;

    typedef struct {
        int            kind;
        bit            iocs;
        bit            iorw;
        bit [1:0]      addr;
        int            src;
        bit [7:0]      data;
        bit [NREQ-1:0] ack;
        bit            rxv;
        bit            busy;
    } slot_t;

    typedef struct {
        int       cyc;
        bit [1:0] addr;
        bit [7:0] data;
    } wr_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic [1:0] br_cfg  = 2'b01;
    logic       cfg_req = 1'b0;
    logic       busy;
    wire  [7:0] databus;
    logic [7:0] spart_rx = 8'h00;

    spart_bus_arb_if #(.NREQ(NREQ)) bif();

    spart_bus_arb #(.NREQ(NREQ)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .br_cfg  (br_cfg),
        .cfg_req (cfg_req),
        .busy    (busy),
        .databus (databus),
        .bus     (bif)
    );

    // SPART side: returns the receive byte whenever the buffer is read.
    assign databus = (bif.iocs && bif.iorw && bif.ioaddr == 2'b00) ? spart_rx : 8'hzz;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit model_live = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic slot_t mk(int kind, bit iocs, bit iorw, bit [1:0] addr, int src,
                                 bit [7:0] data, bit [NREQ-1:0] ack, bit rxv, bit bsy);
        slot_t s;
        s.kind = kind; s.iocs = iocs; s.iorw = iorw; s.addr = addr; s.src = src;
        s.data = data; s.ack = ack; s.rxv = rxv; s.busy = bsy;
        return s;
    endfunction

    function automatic bit [15:0] div_of(bit [1:0] sel);
        case (sel)
            2'b00:   return 16'd1301;
            2'b01:   return 16'd650;
            2'b10:   return 16'd325;
            default: return 16'd162;
        endcase
    endfunction

    // Transaction-level model: a queue of expected bus cycles, refilled at each READY decision.
    slot_t         cur;
    slot_t         sq[$];
    bit [15:0]     m_div;
    bit            m_pend, pend_next;
    int            m_rr;
    bit [7:0]      m_rx;
    bit [NREQ-1:0] m_req_sh;
    bit [8*NREQ-1:0] m_dat_sh;
    int            g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq.delete();
            cur = mk(K_IDLE, 0, 1, 2'b00, 0, 8'h00, '0, 0, 1);
            sq.push_back(mk(K_CLO, 1, 0, 2'b10, 1, 8'h00, '0, 0, 1));
            sq.push_back(mk(K_CHI, 1, 0, 2'b11, 2, 8'h00, '0, 0, 1));
            m_pend = 1'b0;
            m_rr   = NREQ - 1;
            m_rx   = 8'h00;
            m_div  = 16'h0000;
            model_live = 1'b1;
        end else begin
            if (cur.kind == K_CLO) m_div = div_of(br_cfg);
            if (cur.kind == K_RD)  m_rx  = spart_rx;
            pend_next = m_pend | cfg_req;
            if (cur.kind == K_CHI) pend_next = cfg_req;
            if (cur.kind == K_READY) begin
                if (m_pend) begin
                    sq.push_back(mk(K_CLO, 1, 0, 2'b10, 1, 8'h00, '0, 0, 1));
                    sq.push_back(mk(K_CHI, 1, 0, 2'b11, 2, 8'h00, '0, 0, 1));
                end else if (bif.rda) begin
                    sq.push_back(mk(K_RD, 1, 1, 2'b00, 0, 8'h00, '0, 0, 1));
                    sq.push_back(mk(K_RXH, 0, 1, 2'b00, 0, 8'h00, '0, 1, 1));
                end else if (bif.tbr && bif.tx_req != '0) begin
                    g = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        m_req_sh = bif.tx_req >> ((m_rr + k) % NREQ);
                        if (g < 0 && m_req_sh[0]) g = (m_rr + k) % NREQ;
                    end
                    m_rr = g;
                    m_dat_sh = bif.tx_data >> (8 * g);
                    sq.push_back(mk(K_WR, 1, 0, 2'b00, 3, m_dat_sh[7:0], NREQ'(1) << g, 0, 1));
                    sq.push_back(mk(K_TXH, 0, 1, 2'b00, 0, 8'h00, '0, 0, 1));
                end
            end
            m_pend = pend_next;
            if (sq.size() > 0) cur = sq.pop_front();
            else cur = mk(K_READY, 0, 1, 2'b00, 0, 8'h00, '0, 0, 0);
        end
    end

    // Observation logs for the hand-computed directed checks.
    wr_t          wr_log[$];
    int           ack_cyc[$];
    int           ack_id[$];
    int           rd_cyc[$];
    int           rxv_cyc[$];
    bit [7:0]     rxv_dat[$];
    int           acc_cnt = 0;

    logic [15:0]   e16;
    logic [7:0]    ed;
    bit            ok;
    bit [NREQ-1:0] ack_sh;
    wr_t           w;

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (model_live) begin
            e16 = m_div;
            if (cur.src == 1) e16 = div_of(br_cfg);
            ed = (cur.src == 1) ? e16[7:0] : (cur.src == 2) ? e16[15:8] : cur.data;
            ok = (bif.iocs === cur.iocs) && (bif.iorw === cur.iorw) &&
                 (bif.ioaddr === cur.addr) && (bif.tx_ack === cur.ack) &&
                 (bif.rx_valid === cur.rxv) && (bif.rx_data === m_rx) && (busy === cur.busy);
            if (cur.src != 0) ok = ok && (databus === ed);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL model cyc=%0d got iocs=%b iorw=%b addr=%b data=%h ack=%b rxv=%b rxd=%h busy=%b want iocs=%b iorw=%b addr=%b data=%h ack=%b rxv=%b rxd=%h busy=%b",
                         cyc, bif.iocs, bif.iorw, bif.ioaddr, databus, bif.tx_ack, bif.rx_valid,
                         bif.rx_data, busy, cur.iocs, cur.iorw, cur.addr, ed, cur.ack, cur.rxv,
                         m_rx, cur.busy);
            end
        end
        if (rst_n) begin
            if (bif.iocs) acc_cnt++;
            if (bif.iocs && bif.iorw) rd_cyc.push_back(cyc);
            if (bif.iocs && !bif.iorw) begin
                w.cyc = cyc; w.addr = bif.ioaddr; w.data = databus;
                wr_log.push_back(w);
            end
            for (int k = 0; k < NREQ; k++) begin
                ack_sh = bif.tx_ack >> k;
                if (ack_sh[0]) begin
                    ack_cyc.push_back(cyc);
                    ack_id.push_back(k);
                end
            end
            if (bif.rx_valid) begin
                rxv_cyc.push_back(cyc);
                rxv_dat.push_back(bif.rx_data);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete(); ack_cyc.delete(); ack_id.delete(); rd_cyc.delete();
        rxv_cyc.delete(); rxv_dat.delete(); acc_cnt = 0;
    endtask

    task automatic wait_acks(input int n, input int limit);
        int guard;
        guard = 0;
        while (ack_cyc.size() < n && guard < limit) begin
            if (rd_cyc.size() > 0) bif.rda = 1'b0;
            step(1);
            guard++;
        end
        check("ack_wait", int'(ack_cyc.size() >= n), 1);
    endtask

    int r, t;

    initial begin
        bif.tx_req  = '0;
        bif.tx_data = '0;
        bif.rda     = 1'b0;
        bif.tbr     = 1'b0;
        #1 rst_n = 1'b0;
        step(2);

        // Reset release with br_cfg=01: 0x8A@10 then 0x02@11, then READY.
        rst_n = 1'b1;
        r = cyc;
        clear_logs();
        step(2);
        check("cfg_busy_during", int'(busy), 1);
        step(1);
        check("cfg_busy_after", int'(busy), 0);
        check("cfg_nwr", wr_log.size(), 2);
        check("cfg_lo_addr", int'(wr_log[0].addr), 2);
        check("cfg_lo_data", int'(wr_log[0].data), 8'h8A);
        check("cfg_lo_cyc", wr_log[0].cyc, r + 1);
        check("cfg_hi_addr", int'(wr_log[1].addr), 3);
        check("cfg_hi_data", int'(wr_log[1].data), 8'h02);
        check("cfg_hi_cyc", wr_log[1].cyc, r + 2);

        // Both clients requesting: alternate 0,1,0,1 every 3 cycles.
        clear_logs();
        bif.tbr     = 1'b1;
        bif.tx_data = {8'hB2, 8'hA1};
        bif.tx_req  = 2'b11;
        wait_acks(4, 40);
        bif.tx_req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check("rr_ack_id", ack_id[i], i % 2);
            check("rr_wr_data", int'(wr_log[i].data), (i % 2 == 0) ? 8'hA1 : 8'hB2);
            check("rr_wr_addr", int'(wr_log[i].addr), 0);
            if (i > 0) check("rr_spacing", wr_log[i].cyc - wr_log[i-1].cyc, 3);
        end
        step(3);

        // rda and tx_req[1] together: read first, rx_valid 2 cycles later, then the write.
        clear_logs();
        spart_rx   = 8'h5C;
        bif.rda    = 1'b1;
        bif.tx_req = 2'b10;
        t = cyc;
        wait_acks(1, 20);
        bif.tx_req = 2'b00;
        bif.rda    = 1'b0;
        check("rx_rd_cyc", rd_cyc[0], t + 1);
        check("rx_valid_cyc", rxv_cyc[0], t + 2);
        check("rx_valid_data", int'(rxv_dat[0]), 8'h5C);
        check("rx_then_tx_id", ack_id[0], 1);
        check("rx_then_tx_cyc", ack_cyc[0], t + 4);
        check("rx_then_tx_data", int'(wr_log[0].data), 8'hB2);
        step(2);

        // tbr low holds off the write entirely; tbr rising gives an ack next cycle.
        clear_logs();
        bif.tbr    = 1'b0;
        bif.tx_req = 2'b01;
        step(10);
        check("tbr0_no_iocs", acc_cnt, 0);
        check("tbr0_no_ack", ack_cyc.size(), 0);
        check("tbr0_idle", int'(busy), 0);
        bif.tbr = 1'b1;
        t = cyc;
        wait_acks(1, 10);
        bif.tx_req = 2'b00;
        check("tbr_rise_ack_cyc", ack_cyc[0], t + 1);
        check("tbr_rise_ack_id", ack_id[0], 0);
        step(3);

        // cfg_req during TX_WR with br_cfg=11: write completes, then 0xA2@10, 0x00@11.
        clear_logs();
        br_cfg     = 2'b11;
        bif.tx_req = 2'b01;
        t = cyc;
        step(1);
        cfg_req = 1'b1;
        step(1);
        cfg_req    = 1'b0;
        bif.tx_req = 2'b00;
        step(4);
        check("recfg_nwr", wr_log.size(), 3);
        check("recfg_tx_cyc", wr_log[0].cyc, t + 1);
        check("recfg_tx_data", int'(wr_log[0].data), 8'hA1);
        check("recfg_lo", {wr_log[1].addr, wr_log[1].data}, {2'b10, 8'hA2});
        check("recfg_lo_cyc", wr_log[1].cyc, t + 4);
        check("recfg_hi", {wr_log[2].addr, wr_log[2].data}, {2'b11, 8'h00});
        check("recfg_hi_cyc", wr_log[2].cyc, t + 5);
        check("recfg_ready", int'(busy), 0);

        // Reset asserted mid TX_WR: bus released at once, full sequence reruns, client 0 first.
        br_cfg     = 2'b01;
        bif.tx_req = 2'b01;
        step(1);
        check("pre_rst_iocs", int'(bif.iocs), 1);
        rst_n = 1'b0;
        #1;
        check("rst_iocs", int'(bif.iocs), 0);
        check("rst_iorw", int'(bif.iorw), 1);
        check("rst_ack", int'(bif.tx_ack), 0);
        check("rst_busy", int'(busy), 1);
        step(2);
        rst_n = 1'b1;
        r = cyc;
        clear_logs();
        bif.tx_req = 2'b11;
        wait_acks(1, 20);
        bif.tx_req = 2'b00;
        check("rerun_lo", {wr_log[0].addr, wr_log[0].data}, {2'b10, 8'h8A});
        check("rerun_lo_cyc", wr_log[0].cyc, r + 1);
        check("rerun_hi", {wr_log[1].addr, wr_log[1].data}, {2'b11, 8'h02});
        check("rerun_ack_cyc", ack_cyc[0], r + 4);
        check("rerun_ack_id", ack_id[0], 0);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
